addsub_pipe: RTL
================

Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement add/subtract unit with valid/ready handshakes on input and output.
- Next generation of the team's fixed 36-bit combinational add/sub datapath.
- The carry chain is split into CHUNK-bit slices, one pipeline stage per slice, so wide operands close timing.
- Sits between operand-select logic and the result writeback path; backpressure from writeback stalls the pipe without data loss.

Parameters:
- WIDTH, 36: operand and result width in bits.
- CHUNK, 12: bits resolved per pipeline stage. WIDTH % CHUNK must be 0, otherwise an elaboration-time error.
- STAGES, WIDTH/CHUNK: derived localparam; pipeline depth and latency.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset. Assertion clears state immediately; deassertion is synchronised externally.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit accepts the beat this cycle.
- in_a  input  WIDTH  minuend / addend.
- in_b  input  WIDTH  subtrahend / addend.
- in_op  input  1  1 = add (a+b), 0 = subtract (a-b).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  result, modulo 2^WIDTH.

Behaviour:
- Arithmetic:
  - add: a + b + 0.
  - sub: a + ~b + 1.
  - The inversion and carry-in are applied at stage 0. Result is truncated to WIDTH bits; there is no sign extension.
- Stage k (0..STAGES-1) registers:
  - valid_k.
  - result bits [(k+1)*CHUNK-1:0].
  - Unconsumed upper chunks of a and the conditioned b.
  - carry_k out of slice k.
  - Stage k+1 adds its slice using carry_k as carry-in.
- Handshake:
  - A transfer occurs when valid && ready are both high in the same cycle.
  - ready_k = !valid_k || ready_{k+1}; ready_STAGES = out_ready; in_ready = ready_0.
  - This is bubble-collapsing: an empty stage accepts even while downstream is stalled.
- Output timing:
  - out_valid = valid_{STAGES-1}; out_sum = that stage's result register.
  - Both hold stable while out_valid && !out_ready.
- Latency: STAGES cycles from input accept to out_valid, with no backpressure. Throughput is one result per cycle.
- Simultaneous events: a stage may be drained and refilled in the same cycle, giving full throughput under continuous out_ready.
- Ordering: results exit in acceptance order. No reordering, no drops, no duplicates.
- Reset values:
  - All valid_k = 0, so out_valid = 0.
  - in_ready = 1 once reset is released (combinationally 1 while all stages are empty).
  - out_sum = 0; data registers are also cleared.
- Reset mid-operation: in-flight beats are discarded; no partial result appears after reset.
- Wrap-around:
  - add of all-ones + 1 gives 0.
  - sub 0 - 1 gives all-ones.
- in_a, in_b and in_op are sampled only on an accepting cycle; values on other cycles are ignored.

Optional Feature:
- ADDSUB_PIPE_FLAGS_EN: adds output ports out_cout (1) and out_ovf (1), aligned with out_sum and held under stall.
  - out_cout is the carry out of the MSB (for sub, 1 = no borrow).
  - out_ovf is signed overflow: carry into MSB XOR carry out of MSB.
  - Both reset to 0.
- Macro undefined: the ports and the associated registers do not exist.

Decomposition:
- Package addsub_pkg holds:
  - localparam OP_SUB = 1'b0 and OP_ADD = 1'b1.
  - A function for the per-slice conditioned-b computation.
- Sub-module addsub_slice: combinational CHUNK-bit adder (a, b, cin -> sum, cout, plus carry-into-MSB for the overflow flag). It is instantiated once per stage inside a generate loop.

Test Plan:
- WIDTH=36, CHUNK=12, out_ready=1. Accept a=0x000000005, b=0x000000003, op=1 -> out_sum=0x000000008 exactly 3 cycles later. Same operands with op=0 -> 0x000000002.
- Carry across all slices: a=0x000000FFF, b=0x000000001, op=1 -> 0x000001000. a=0xFFFFFFFFF, b=1, op=1 -> 0x000000000 (flags build: cout=1, ovf=0).
- Borrow wrap: a=0, b=1, op=0 -> 0xFFFFFFFFF (flags build: cout=0, ovf=0). Signed overflow: a=0x7FFFFFFFF, b=1, op=1 -> 0x800000000 with ovf=1.
- Backpressure: stream 10 random beats with out_ready held low for cycles 4-9.
  - in_ready falls once 3 beats are in flight.
  - out_sum holds stable while stalled.
  - All 10 results match the reference model in order.
  - Back-to-back throughput of 1 per cycle after release.
- Bubble collapse: send beat, idle 2 cycles, send beat with out_ready=0 -> both stages fill, in_ready=1 until the pipe is full.
- Reset: assert rst_n low with 2 beats in flight -> out_valid=0 immediately. After release, no stale result appears and the first new beat returns with 3-cycle latency.

Source files
------------

// File: rtl/addsub_pkg.sv
// Opcode encoding and operand-conditioning helpers shared by the addsub_pipe datapath.
package addsub_pkg;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // One bit of the conditioned b operand: inverted for subtract so a - b becomes a + ~b + 1.
  function automatic logic cond_b_bit(input logic b, input logic op);
    return b ^ (op == OP_SUB);
  endfunction

  // Carry into slice 0 supplies the +1 of the two's-complement subtract.
  function automatic logic carry_in(input logic op);
    return (op == OP_SUB);
  endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result valid-ready bundle for addsub_pipe; ADDSUB_PIPE_FLAGS_EN adds carry/overflow flags.
interface addsub_pipe_if #(
  parameter int WIDTH = 36
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
`ifdef ADDSUB_PIPE_FLAGS_EN
  logic             out_cout;
  logic             out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
`ifdef ADDSUB_PIPE_FLAGS_EN
    input  out_cout, out_ovf,
`endif
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
`ifdef ADDSUB_PIPE_FLAGS_EN
    output out_cout, out_ovf,
`endif
    output in_ready, out_valid, out_sum
  );

endinterface

// File: rtl/addsub_slice.sv
// Combinational W-bit adder slice; also exposes the carry into its MSB for signed-overflow detection.
module addsub_slice #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  if (W < 2) begin : g_bad_width
    $error("addsub_slice: W (%0d) must be at least 2", W);
  end

  logic [W-1:0] low;
  logic [1:0]   top;

  // The MSB is added separately so the carry into it is visible for the overflow flag.
  always_comb begin
    low = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + W'(cin);
    top = {1'b0, a[W-1]} + {1'b0, b[W-1]} + {1'b0, low[W-1]};
  end

  assign sum   = {top[0], low[W-2:0]};
  assign cout  = top[1];
  assign c_msb = low[W-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub: one CHUNK-bit carry slice per stage, bubble-collapsing valid/ready.
// Define ADDSUB_PIPE_FLAGS_EN to add registered carry-out and signed-overflow outputs.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int CHUNK = 12
) (
  input logic          clk,
  input logic          rst_n,
  addsub_pipe_if.slave bus
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int OPS    = (STAGES > 1) ? STAGES - 1 : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("addsub_pipe: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] ready, load;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic [WIDTH-1:0]  a_q   [OPS];
  logic [WIDTH-1:0]  a_d   [OPS];
  logic [WIDTH-1:0]  b_q   [OPS];
  logic [WIDTH-1:0]  b_d   [OPS];
  logic [OPS-1:0]    carry_q, carry_d;

  logic [WIDTH-1:0]  b_in;
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_res [STAGES];
  logic [STAGES-1:0] src_v, src_c;
  logic [CHUNK-1:0]  sl_a    [STAGES];
  logic [CHUNK-1:0]  sl_b    [STAGES];
  wire  [CHUNK-1:0]  sl_sum  [STAGES];
  wire  [STAGES-1:0] sl_cout, sl_cmsb;

  // What each stage would load: stage 0 from the port, stage k from stage k-1's registers.
  always_comb begin
    // NOTE: every variable gets a default before any conditional or loop write, so no latch is inferred.
    b_in = '0;
    for (int i = 0; i < WIDTH; i++) b_in[i] = cond_b_bit(bus.in_b[i], bus.in_op);
    src_a[0]   = bus.in_a;
    src_b[0]   = b_in;
    src_res[0] = '0;
    src_v      = '0;
    src_c      = '0;
    src_v[0]   = bus.in_valid;
    src_c[0]   = carry_in(bus.in_op);
    for (int k = 1; k < STAGES; k++) begin
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_res[k] = res_q[k-1];
      src_v[k]   = valid_q[k-1];
      src_c[k]   = carry_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sl_a[k] = src_a[k][k*CHUNK +: CHUNK];
      sl_b[k] = src_b[k][k*CHUNK +: CHUNK];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_slice #(.W(CHUNK)) u_slice (
      .a    (sl_a[k]),
      .b    (sl_b[k]),
      .cin  (src_c[k]),
      .sum  (sl_sum[k]),
      .cout (sl_cout[k]),
      .c_msb(sl_cmsb[k])
    );
  end

  always_comb begin
    logic rdy;
    valid_d = valid_q;
    load    = '0;
    ready   = '0;
    carry_d = carry_q;
    // A stage can take a beat when it is empty or anything further down can move.
    rdy = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy      = rdy || !valid_q[k];
      ready[k] = rdy;
    end
    for (int k = 0; k < STAGES; k++) begin
      load[k]  = ready[k] && src_v[k];
      res_d[k] = res_q[k];
      if (ready[k]) valid_d[k] = src_v[k];
      if (load[k]) begin
        res_d[k]                    = src_res[k];
        res_d[k][k*CHUNK +: CHUNK] = sl_sum[k];
      end
    end
    for (int k = 0; k < OPS; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      if (k < STAGES - 1 && load[k]) begin
        a_d[k]     = src_a[k];
        b_d[k]     = src_b[k];
        carry_d[k] = sl_cout[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are cleared too, so out_sum reads 0 out of reset rather than X.
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) res_q[k] <= '0;
      for (int k = 0; k < OPS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every stage sampling the pre-edge value of its neighbour.
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int k = 0; k < STAGES; k++) res_q[k] <= res_d[k];
      for (int k = 0; k < OPS; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

`ifdef ADDSUB_PIPE_FLAGS_EN
  logic cout_q, cout_d, ovf_q, ovf_d;

  // Flags come from the top slice and load together with the final result chunk.
  always_comb begin
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (load[STAGES-1]) begin
      cout_d = sl_cout[STAGES-1];
      ovf_d  = sl_cout[STAGES-1] ^ sl_cmsb[STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.out_cout = cout_q;
  assign bus.out_ovf  = ovf_q;
`endif

  logic unused_slice;
  assign unused_slice = ^{sl_cmsb, sl_cout[STAGES-1]};

  assign bus.in_ready  = ready[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_sum   = res_q[STAGES-1];

endmodule
